// File: rtl/fdiv_seq.sv
// fdiv_seq: iterative IEEE-754 single-precision divider (d = s / t).
// Radix-2 restoring division of the 24-bit mantissas produces 27 quotient
// bits. One round-to-nearest-even cycle follows. Denormal inputs and
// results are flushed to zero. Valid/ready handshakes are used on both
// the operand side and the result side.
module fdiv_seq #(
  parameter int QBITS = 27
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] s,
  input  logic [31:0] t,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] d,
  output logic        overflow,
  output logic        underflow,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic               sign_r;
  logic [7:0]         es;
  logic [7:0]         et;
  logic [24:0]        rem;
  logic [23:0]        dvs;
  logic [QBITS-1:0]   q;
  logic [4:0]         cnt;

  // operand classification; exponent 0 means zero (denormals flushed)
  logic [7:0]  s_exp, t_exp;
  logic [22:0] s_man, t_man;
  logic        s_nan, t_nan, s_inf, t_inf, s_zero, t_zero;
  logic        special_hit;
  logic [31:0] special_d;
  logic        sign_in;

  assign s_exp   = s[30:23];
  assign t_exp   = t[30:23];
  assign s_man   = s[22:0];
  assign t_man   = t[22:0];
  assign s_nan   = (&s_exp) && (|s_man);
  assign t_nan   = (&t_exp) && (|t_man);
  assign s_inf   = (&s_exp) && !(|s_man);
  assign t_inf   = (&t_exp) && !(|t_man);
  assign s_zero  = (s_exp == 8'd0);
  assign t_zero  = (t_exp == 8'd0);
  assign sign_in = s[31] ^ t[31];

  // The idle state is the only one that can take operands
  assign in_ready = (state == IDLE);

  // Special-case result selection in priority order (NaN payloads are quietened)
  always_comb begin
    special_hit = 1'b1;
    special_d   = 32'd0;
    if (s_nan) begin
      special_d = {s[31], 8'hFF, 1'b1, s[21:0]};
    end else if (t_nan) begin
      special_d = {t[31], 8'hFF, 1'b1, t[21:0]};
    end else if ((s_inf && t_inf) || (s_zero && t_zero)) begin
      special_d = 32'h7FC00000;
    end else if (s_inf || t_zero) begin
      special_d = {sign_in, 8'hFF, 23'd0};
    end else if (s_zero || t_inf) begin
      special_d = {sign_in, 31'd0};
    end else begin
      special_hit = 1'b0;
    end
  end

  // One restoring step: subtract the divisor when it fits and emit the quotient bit
  logic        q_bit;
  logic [24:0] rem_sub;

  always_comb begin
    q_bit   = (rem >= {1'b0, dvs});
    rem_sub = q_bit ? (rem - {1'b0, dvs}) : rem;
  end

  // Normalise the quotient, round to nearest-even and classify the exponent
  logic [23:0] m;
  logic        g, st, up;
  logic [24:0] m_rnd;
  logic [9:0]  bias;
  logic [9:0]  e_raw;
  logic        e_over, e_under;
  logic [31:0] round_d;

  always_comb begin
    if (q[QBITS-1]) begin
      m    = q[QBITS-1:3];
      g    = q[2];
      st   = (|q[1:0]) | (rem != 25'd0);
      bias = 10'd127;
    end else begin
      m    = q[QBITS-2:2];
      g    = q[1];
      st   = q[0] | (rem != 25'd0);
      bias = 10'd126;
    end
    up      = g && (st || m[0]);
    m_rnd   = {1'b0, m} + {24'd0, up};
    e_raw   = {2'b00, es} - {2'b00, et} + bias + {9'd0, m_rnd[24]};
    e_over  = !e_raw[9] && (e_raw >= 10'd255);
    e_under = e_raw[9] || (e_raw == 10'd0);
    if (e_over) begin
      round_d = {sign_r, 8'hFF, 23'd0};
    end else if (e_under) begin
      round_d = {sign_r, 31'd0};
    end else begin
      round_d = {sign_r, e_raw[7:0], m_rnd[22:0]};
    end
  end

  // Control FSM with registered result and handshake outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      sign_r    <= 1'b0;
      es        <= 8'd0;
      et        <= 8'd0;
      rem       <= 25'd0;
      dvs       <= 24'd0;
      q         <= '0;
      cnt       <= 5'd0;
      d         <= 32'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= sign_in;
            es     <= s_exp;
            et     <= t_exp;
            if (special_hit) begin
              d         <= special_d;
              overflow  <= 1'b0;
              underflow <= 1'b0;
              state     <= DONE;
            end else begin
              rem   <= {2'b01, s_man};
              dvs   <= {1'b1, t_man};
              q     <= '0;
              cnt   <= 5'd0;
              state <= DIV;
            end
          end
        end
        DIV: begin
          q   <= {q[QBITS-2:0], q_bit};
          rem <= rem_sub << 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(QBITS - 1)) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          d         <= round_d;
          overflow  <= e_over;
          underflow <= !e_over && e_under;
          state     <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed self-checking bench for the sequential divider.
module tb_fdiv_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] s = 32'd0;
  logic [31:0] t = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] d;
  logic        overflow;
  logic        underflow;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checkCount = 0;
  int errorCount = 0;

  fdiv_seq #(.QBITS(27)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s         (s),
    .t         (t),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .overflow  (overflow),
    .underflow (underflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one division, measure latency, optionally stall the result, then retire it
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expD, input logic [1:0] expFlags,
                               input int expLat, input int holdCycles);
    int   lat;
    logic readyLeak;
    checkOutput({tag, " in_ready before"}, 32'(in_ready), 32'd1);
    s        = a;
    t        = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    s         = 32'hDEADBEEF;
    t         = 32'h12345678;
    lat       = 0;
    readyLeak = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) readyLeak = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " in_ready busy"}, 32'(readyLeak | in_ready), 32'd0);
    checkOutput({tag, " d"}, d, expD);
    checkOutput({tag, " flags"}, 32'({overflow, underflow}), 32'(expFlags));
    for (int i = 0; i < holdCycles; i++) begin
      in_valid = 1'b1;
      s        = 32'h3F800000;
      t        = 32'h3F800000;
      @(posedge clk);
      #1;
      checkOutput({tag, " hold d"}, d, expD);
      checkOutput({tag, " hold flags"}, 32'({overflow, underflow}), 32'(expFlags));
      checkOutput({tag, " hold valid"}, 32'({out_valid, in_ready}), 32'b10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, " retire"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  // Safety net in case the DUT stalls the whole run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    #12;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset d", d, 32'd0);
    checkOutput("reset flags", 32'({overflow, underflow}), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("6/2",      32'h40C00000, 32'h40000000, 32'h40400000, 2'b00, 29, 0);
    applyStimulus("1/3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 2'b00, 29, 0);
    applyStimulus("1/1",      32'h3F800000, 32'h3F800000, 32'h3F800000, 2'b00, 29, 0);
    applyStimulus("1/0",      32'h3F800000, 32'h00000000, 32'h7F800000, 2'b00, 1, 0);
    applyStimulus("0/0",      32'h00000000, 32'h00000000, 32'h7FC00000, 2'b00, 1, 0);
    applyStimulus("nan/1",    32'h7FA00000, 32'h3F800000, 32'h7FE00000, 2'b00, 1, 0);
    applyStimulus("-1/inf",   32'hBF800000, 32'h7F800000, 32'h80000000, 2'b00, 1, 0);
    applyStimulus("ovf",      32'h7F000000, 32'h3E800000, 32'h7F800000, 2'b10, 29, 0);
    applyStimulus("unf",      32'h00800000, 32'h40000000, 32'h00000000, 2'b01, 29, 0);
    applyStimulus("-2/0.5",   32'hC0000000, 32'h3F000000, 32'hC0800000, 2'b00, 29, 0);
    applyStimulus("stall",    32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 2'b00, 29, 5);
    applyStimulus("b2b a",    32'h40C00000, 32'h40000000, 32'h40400000, 2'b00, 29, 0);
    applyStimulus("b2b b",    32'hC0000000, 32'h3F000000, 32'hC0800000, 2'b00, 29, 0);

    s        = 32'h40C00000;
    t        = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midop busy", 32'(in_ready), 32'd0);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("midop reset valid", 32'(out_valid), 32'd0);
    checkOutput("midop reset d", d, 32'd0);
    checkOutput("midop reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("midop reset flags", 32'({overflow, underflow}), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("after rst", 32'h40C00000, 32'h40000000, 32'h40400000, 2'b00, 29, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fdiv_seq.md
Name: fdiv_seq

Overview:
- Iterative single-precision IEEE-754 divider: d = s / t. It is the inverse operation of the FPU's combinational multiplier.
- Radix-2 restoring mantissa division over multiple cycles, with valid/ready handshakes on input and output.
- Sits in the FPU beside the multiplier. The core stalls on in_ready / out_valid.
- Denormal inputs are flushed to zero, and denormal results are flushed to zero.

Parameters:
- QBITS, 27, number of quotient bits produced by iteration (24 mantissa + guard + 2 extra). Fixed at 27; other values are unsupported.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rstn  in  1  asynchronous active-low reset
- s  in  32  dividend, IEEE-754 single
- t  in  32  divisor, IEEE-754 single
- in_valid  in  1  operands valid
- in_ready  out  1  divider idle; can accept
- d  out  32  quotient
- overflow  out  1  finite result exceeded the range; d = ±inf
- underflow  out  1  finite result below the normal range; d = ±0
- out_valid  out  1  d and flags valid
- out_ready  in  1  consumer takes the result

Behaviour:
- Reset: asynchronous; rstn low immediately forces the following, including mid-division. Any operation in flight is discarded.
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - d = 0, overflow = 0, underflow = 0
  - all internal registers = 0
- States: IDLE, DIV, ROUND, DONE.
  - in_ready = 1 only in IDLE.
- IDLE: on in_valid && in_ready, capture s and t.
  - Special case → compute d directly and go to DONE.
  - Otherwise → load rem = {1,mant_s}, div = {1,mant_t}, q = 0, cnt = 0, and go to DIV.
- DIV, one step per cycle:
  - If rem >= div: qbit = 1 and rem -= div.
  - Then q = {q[25:0], qbit}, rem <<= 1, cnt++.
  - After the 27th step go to ROUND.
  - rem is 25 bits wide; no overflow is possible.
- ROUND, one cycle:
  - If q[26] = 1: m = q[26:3], g = q[2], st = |q[1:0] | (rem != 0), e = es − et + 127.
  - If q[26] = 0: m = q[25:2], g = q[1], st = q[0] | (rem != 0), e = es − et + 126.
  - Round to nearest-even: up = g && (st || m[0]).
  - m' = m + up. If m' = 2^24, e += 1 and the mantissa becomes 0.
  - e is computed as a 10-bit signed value.
  - e >= 255 → d = {sign, 8'hFF, 0}, overflow = 1.
  - e <= 0 → d = {sign, 0, 0}, underflow = 1.
  - Otherwise d = {sign, e[7:0], m'[22:0]}.
  - Go to DONE.
- Sign: sign = s[31] ^ t[31] in every case except NaN outputs.
- Special cases, evaluated in priority order. Inputs with exponent 0 are treated as ±0.
  1. s is NaN → {s[31], 8'hFF, 1, s[21:0]}.
  2. t is NaN → {t[31], 8'hFF, 1, t[21:0]}.
  3. inf/inf or 0/0 → 32'h7FC00000.
  4. s = inf or t = 0 → ±inf.
  5. s = 0 or t = inf → ±0.
  - overflow and underflow are 0 for all special cases.
- DONE:
  - out_valid = 1; d, overflow and underflow are held stable.
  - On out_ready = 1: out_valid drops at the next edge and the state returns to IDLE.
  - A new operand is accepted no earlier than the cycle after out_valid falls. There is no same-cycle accept/complete.
- Latency, counted from the acceptance edge:
  - Normal operands: out_valid rises 29 edges later (27 DIV + 1 ROUND + 1).
  - Special cases: out_valid rises 1 edge later.
- in_valid and operand changes outside IDLE are ignored.
- out_ready while out_valid = 0 is ignored.

Test Plan:
- 6.0/2.0: s = 40C00000, t = 40000000 → d = 40400000, flags 0, out_valid exactly 29 edges after accept, in_ready = 0 throughout.
- 1.0/3.0: s = 3F800000, t = 40400000 → d = 3EAAAAAB (round-up path). Also 3F800000 / 3F800000 → 3F800000.
- Specials, each out_valid 1 edge after accept:
  - 3F800000 / 00000000 → 7F800000
  - 00000000 / 00000000 → 7FC00000
  - 7FA00000 / 3F800000 → 7FE00000
  - BF800000 / 7F800000 → 80000000
- Range flags:
  - 7F000000 / 3E800000 → 7F800000, overflow = 1
  - 00800000 / 40000000 → 00000000, underflow = 1
  - C0000000 / 3F000000 → C0800000, flags 0
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid → d and flags stable, in_valid ignored. After the out_ready pulse, in_ready = 1 next cycle and back-to-back ops return correct results.
- Reset mid-op: pull rstn low at DIV cycle 10 → out_valid = 0, d = 0, in_ready = 1 immediately (asynchronous). After release, 40C00000 / 40000000 → 40400000 in 29 edges.
